// File: rtl/uart_core.sv
// Full-duplex UART engine: free-running oversampling baud generator, valid/ready
// transmitter and majority-vote receiver with parity and framing error flags.
module uart_core #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned OSR    = 16,
    parameter int unsigned DIV_W  = 16
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [DIV_W-1:0]  baud_div_i,
    input  logic              tx_en_i,
    input  logic              rx_en_i,
    input  logic              parity_en_i,
    input  logic              parity_odd_i,
    input  logic              two_stop_i,
    input  logic [DATA_W-1:0] tx_data_i,
    input  logic              tx_valid_i,
    output logic              tx_ready_o,
    output logic              tx_done_o,
    output logic              tx_o,
    input  logic              rx_i,
    output logic [DATA_W-1:0] rx_data_o,
    output logic              rx_valid_o,
    output logic              rx_parity_err_o,
    output logic              rx_frame_err_o
);
    localparam int unsigned CW = $clog2(OSR);
    localparam int unsigned BW = $clog2(DATA_W);
    localparam logic [CW-1:0] LAST_TICK = CW'(OSR - 1);
    localparam logic [CW-1:0] SAMP_A    = CW'(OSR / 2 - 1);
    localparam logic [CW-1:0] SAMP_B    = CW'(OSR / 2);
    localparam logic [CW-1:0] SAMP_C    = CW'(OSR / 2 + 1);
    localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_W - 1);

    typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_t;
    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP, RX_BREAK} rx_state_t;

    tx_state_t         tx_state;
    logic [CW-1:0]     tx_tick_cnt;
    logic [BW-1:0]     tx_bit_cnt;
    logic [DATA_W-1:0] tx_shift;
    logic              tx_par, tx_par_en, tx_two_stop, tx_stop2;

    rx_state_t         rx_state;
    logic [CW-1:0]     rx_tick_cnt;
    logic [BW-1:0]     rx_bit_cnt;
    logic [DATA_W-1:0] rx_shift;
    logic              rx_s1, rx_s2, samp_a, samp_b, rx_par_bad, maj;

    logic [DIV_W-1:0]  baud_cnt;
    logic              baud_run, tick;

    // The generator also runs while a frame is in flight so a disabled TX can finish.
    assign baud_run = tx_en_i | rx_en_i | (tx_state != TX_IDLE);
    assign tick     = baud_run && (baud_cnt == baud_div_i);

    always_ff @(posedge clk_i) begin
        if (!rst_ni || !baud_run || baud_cnt == baud_div_i) baud_cnt <= '0;
        else                                                  baud_cnt <= baud_cnt + DIV_W'(1);
    end

    assign tx_ready_o = tx_en_i && (tx_state == TX_IDLE);
    assign tx_done_o  = (tx_state == TX_STOP) && tick && (tx_tick_cnt == LAST_TICK)
                        && (!tx_two_stop || tx_stop2);

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            tx_state    <= TX_IDLE;
            tx_o        <= 1'b1;
            tx_tick_cnt <= '0;
            tx_bit_cnt  <= '0;
            tx_shift    <= '0;
            tx_par      <= 1'b0;
            tx_par_en   <= 1'b0;
            tx_two_stop <= 1'b0;
            tx_stop2    <= 1'b0;
        end else begin
            case (tx_state)
                TX_IDLE: begin
                    if (tx_valid_i && tx_ready_o) begin
                        tx_shift    <= tx_data_i;
                        tx_par      <= ^tx_data_i ^ parity_odd_i;
                        tx_par_en   <= parity_en_i;
                        tx_two_stop <= two_stop_i;
                        tx_stop2    <= 1'b0;
                        tx_tick_cnt <= '0;
                        tx_bit_cnt  <= '0;
                        tx_o        <= 1'b0;
                        tx_state    <= TX_START;
                    end
                end
                default: begin
                    if (tick) begin
                        tx_tick_cnt <= tx_tick_cnt + CW'(1);
                        if (tx_tick_cnt == LAST_TICK) begin
                            case (tx_state)
                                TX_START: begin
                                    tx_o     <= tx_shift[0];
                                    tx_state <= TX_DATA;
                                end
                                TX_DATA: begin
                                    tx_shift   <= tx_shift >> 1;
                                    tx_bit_cnt <= tx_bit_cnt + BW'(1);
                                    if (tx_bit_cnt != LAST_BIT) begin
                                        tx_o <= tx_shift[1];
                                    end else if (tx_par_en) begin
                                        tx_o     <= tx_par;
                                        tx_state <= TX_PARITY;
                                    end else begin
                                        tx_o     <= 1'b1;
                                        tx_state <= TX_STOP;
                                    end
                                end
                                TX_PARITY: begin
                                    tx_o     <= 1'b1;
                                    tx_state <= TX_STOP;
                                end
                                TX_STOP: begin
                                    if (tx_two_stop && !tx_stop2) tx_stop2 <= 1'b1;
                                    else                          tx_state <= TX_IDLE;
                                end
                                default: tx_state <= TX_IDLE;
                            endcase
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) {rx_s1, rx_s2} <= 2'b11;
        else         {rx_s1, rx_s2} <= {rx_i, rx_s1};
    end

    assign maj = (samp_a & samp_b) | (samp_a & rx_s2) | (samp_b & rx_s2);

    // rx_tick_cnt holds the index of the next tick within the current bit;
    // the tick that detects the start edge is index 0.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            rx_state        <= RX_IDLE;
            rx_tick_cnt     <= '0;
            rx_bit_cnt      <= '0;
            rx_shift        <= '0;
            samp_a          <= 1'b1;
            samp_b          <= 1'b1;
            rx_par_bad      <= 1'b0;
            rx_valid_o      <= 1'b0;
            rx_data_o       <= '0;
            rx_parity_err_o <= 1'b0;
            rx_frame_err_o  <= 1'b0;
        end else begin
            rx_valid_o <= 1'b0;
            if (!rx_en_i) begin
                rx_state <= RX_IDLE;
            end else begin
                case (rx_state)
                    RX_IDLE: begin
                        if (tick && !rx_s2) begin
                            rx_state    <= RX_START;
                            rx_tick_cnt <= CW'(1);
                            rx_bit_cnt  <= '0;
                            rx_par_bad  <= 1'b0;
                        end
                    end
                    RX_BREAK: begin
                        if (rx_s2) rx_state <= RX_IDLE;
                    end
                    default: begin
                        if (tick) begin
                            rx_tick_cnt <= rx_tick_cnt + CW'(1);
                            if (rx_tick_cnt == SAMP_A) samp_a <= rx_s2;
                            if (rx_tick_cnt == SAMP_B) samp_b <= rx_s2;
                            if (rx_tick_cnt == SAMP_C) begin
                                case (rx_state)
                                    RX_START: rx_state <= maj ? RX_IDLE : RX_DATA;
                                    RX_DATA: begin
                                        rx_shift   <= {maj, rx_shift[DATA_W-1:1]};
                                        rx_bit_cnt <= rx_bit_cnt + BW'(1);
                                        if (rx_bit_cnt == LAST_BIT)
                                            rx_state <= parity_en_i ? RX_PARITY : RX_STOP;
                                    end
                                    RX_PARITY: begin
                                        rx_par_bad <= maj ^ (^rx_shift) ^ parity_odd_i;
                                        rx_state   <= RX_STOP;
                                    end
                                    RX_STOP: begin
                                        rx_valid_o      <= 1'b1;
                                        rx_data_o       <= rx_shift;
                                        rx_parity_err_o <= rx_par_bad;
                                        rx_frame_err_o  <= !maj;
                                        rx_state        <= maj ? RX_IDLE : RX_BREAK;
                                    end
                                    default: rx_state <= RX_IDLE;
                                endcase
                            end
                        end
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_uart_core.sv
// Bench for uart_core: table-driven RX frames, hand-written corner sequences and
// randomized TX/RX frames checked against a frame-level reference model.
module tb_uart_core;
    localparam int P  = 5;
    localparam int BP = 16 * P;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       tx_en, rx_en, par_en, par_odd, two_stop, tx_valid;
    logic [7:0] tx_data;
    logic       tx_ready_o, tx_done_o, tx_o;
    logic [7:0] rx_data_o;
    logic       rx_valid_o, rx_perr_o, rx_ferr_o;
    logic       loop_en, rx_drive, rx_line;

    logic       en7, tx7_valid;
    logic [6:0] tx7_data;
    logic       tx7_ready, tx7_done, tx7_o, rx7_valid, rx7_perr, rx7_ferr;
    logic [6:0] rx7_data;

    int n_vec = 0;
    int n_bad = 0;
    int rx_cnt = 0;
    int rx7_cnt = 0;
    int done_cnt = 0;
    logic fbits[$];

    always #5 clk = ~clk;
    assign rx_line = loop_en ? tx_o : rx_drive;

    uart_core #(.DATA_W(8), .OSR(16), .DIV_W(16)) dut (
        .clk_i(clk), .rst_ni(rst_n), .baud_div_i(16'd4),
        .tx_en_i(tx_en), .rx_en_i(rx_en), .parity_en_i(par_en), .parity_odd_i(par_odd),
        .two_stop_i(two_stop), .tx_data_i(tx_data), .tx_valid_i(tx_valid),
        .tx_ready_o(tx_ready_o), .tx_done_o(tx_done_o), .tx_o(tx_o), .rx_i(rx_line),
        .rx_data_o(rx_data_o), .rx_valid_o(rx_valid_o),
        .rx_parity_err_o(rx_perr_o), .rx_frame_err_o(rx_ferr_o)
    );

    uart_core #(.DATA_W(7), .OSR(16), .DIV_W(16)) dut7 (
        .clk_i(clk), .rst_ni(rst_n), .baud_div_i(16'd4),
        .tx_en_i(en7), .rx_en_i(en7), .parity_en_i(1'b1), .parity_odd_i(1'b0),
        .two_stop_i(1'b1), .tx_data_i(tx7_data), .tx_valid_i(tx7_valid),
        .tx_ready_o(tx7_ready), .tx_done_o(tx7_done), .tx_o(tx7_o), .rx_i(tx7_o),
        .rx_data_o(rx7_data), .rx_valid_o(rx7_valid),
        .rx_parity_err_o(rx7_perr), .rx_frame_err_o(rx7_ferr)
    );

    always @(negedge clk) begin
        if (rx_valid_o) rx_cnt <= rx_cnt + 1;
        if (rx7_valid)  rx7_cnt <= rx7_cnt + 1;
        if (tx_done_o)  done_cnt <= done_cnt + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        n_vec++;
        if (act < lo || act > hi) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d..%0d", name, act, lo, hi);
        end
    endtask

    // Reference frame: start, LSB-first data, optional parity, stop bit(s).
    function automatic void build_frame(input int unsigned width, input logic [8:0] d,
                                        input logic pe, input logic po, input logic ts,
                                        input logic flip, input logic stopv);
        logic p;
        fbits.delete();
        fbits.push_back(1'b0);
        p = po;
        for (int unsigned i = 0; i < width; i++) begin
            fbits.push_back(d[i]);
            p = p ^ d[i];
        end
        if (pe) fbits.push_back(p ^ flip);
        fbits.push_back(stopv);
        if (ts) fbits.push_back(1'b1);
    endfunction

    task automatic start_tx(input logic [7:0] d, input logic pe, input logic po,
                            input logic ts, output bit got);
        got = 0;
        for (int c = 0; c < 4000 && !got; c++) begin
            @(negedge clk);
            if (tx_ready_o) got = 1;
        end
        check("tx_ready_wait", 32'(got), 1);
        if (got) begin
            tx_data = d; par_en = pe; par_odd = po; two_stop = ts; tx_valid = 1'b1;
            @(negedge clk);
            tx_valid = 1'b0;
        end
    endtask

    task automatic send_tx(input logic [7:0] d, input logic pe, input logic po, input logic ts);
        logic samp[$];
        bit   got, busy_rdy, done_seen, bad;
        int   s, base;
        logic act;
        start_tx(d, pe, po, ts, got);
        if (!got) return;
        busy_rdy = 0; done_seen = 0;
        for (int c = 0; c < 2000 && !done_seen; c++) begin
            if (c != 0) @(negedge clk);
            samp.push_back(tx_o);
            if (tx_ready_o) busy_rdy = 1;
            if (tx_done_o)  done_seen = 1;
        end
        check("tx_done_seen", 32'(done_seen), 1);
        check("tx_ready_busy", 32'(busy_rdy), 0);
        build_frame(8, {1'b0, d}, pe, po, ts, 1'b0, 1'b1);
        s = samp.size() - (fbits.size() - 1) * BP;
        check_range("tx_start_len", s, BP - P + 1, BP);
        if (s >= BP - P + 1 && s <= BP) begin
            bad = 0;
            for (int c = 0; c < s; c++) if (samp[c] !== 1'b0) bad = 1;
            check("tx_start_bit", 32'(bad), 0);
            for (int i = 1; i < fbits.size(); i++) begin
                base = s + (i - 1) * BP;
                act  = fbits[i];
                for (int c = 0; c < BP; c++) if (samp[base + c] !== fbits[i]) act = samp[base + c];
                check($sformatf("tx_bit%0d", i), 32'(act), 32'(fbits[i]));
            end
        end
        @(negedge clk);
        check("tx_ready_after", 32'(tx_ready_o), 1);
        check("tx_done_single", 32'(tx_done_o), 0);
    endtask

    task automatic drive_rx(input logic [7:0] d, input logic pe, input logic po,
                            input logic flip, input logic stopv, input int gap);
        par_en = pe; par_odd = po;
        build_frame(8, {1'b0, d}, pe, po, 1'b0, flip, stopv);
        foreach (fbits[i]) begin
            rx_drive = fbits[i];
            repeat (BP) @(negedge clk);
        end
        rx_drive = 1'b1;
        repeat (gap) @(negedge clk);
    endtask

    task automatic rx_expect(input int cnt0, input logic [7:0] d, input logic perr, input logic ferr);
        check("rx_count", 32'(rx_cnt - cnt0), 1);
        check("rx_data", 32'(rx_data_o), 32'(d));
        check("rx_parity_err", 32'(rx_perr_o), 32'(perr));
        check("rx_frame_err", 32'(rx_ferr_o), 32'(ferr));
    endtask

    typedef struct {
        logic [7:0] data;
        logic       pe, po, flip, stopv;
        logic [7:0] exp_data;
        logic       exp_perr, exp_ferr;
    } rx_vec_t;

    rx_vec_t vecs[7];

    initial begin
        int   cnt0, d0, t;
        bit   got, busy, done;
        logic [7:0] d;
        logic pe, po, ts, flip, stopv;

        vecs[0] = '{8'h3C, 1'b1, 1'b0, 1'b0, 1'b1, 8'h3C, 1'b0, 1'b0};
        vecs[1] = '{8'h3C, 1'b1, 1'b0, 1'b1, 1'b1, 8'h3C, 1'b1, 1'b0};
        vecs[2] = '{8'h55, 1'b0, 1'b0, 1'b0, 1'b1, 8'h55, 1'b0, 1'b0};
        vecs[3] = '{8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0};
        vecs[4] = '{8'hFF, 1'b1, 1'b0, 1'b1, 1'b1, 8'hFF, 1'b1, 1'b0};
        vecs[5] = '{8'h81, 1'b0, 1'b0, 1'b0, 1'b0, 8'h81, 1'b0, 1'b1};
        vecs[6] = '{8'hA5, 1'b1, 1'b1, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b1};

        rst_n = 1'b0; tx_en = 1'b0; rx_en = 1'b0; par_en = 1'b0; par_odd = 1'b0;
        two_stop = 1'b0; tx_valid = 1'b0; tx_data = '0; loop_en = 1'b0; rx_drive = 1'b1;
        en7 = 1'b0; tx7_valid = 1'b0; tx7_data = '0;
        repeat (3) @(negedge clk);
        check("rst_tx_o", 32'(tx_o), 1);
        check("rst_tx_done", 32'(tx_done_o), 0);
        check("rst_tx_ready", 32'(tx_ready_o), 0);
        check("rst_rx_valid", 32'(rx_valid_o), 0);
        check("rst_rx_data", 32'(rx_data_o), 0);
        check("rst_rx_perr", 32'(rx_perr_o), 0);
        check("rst_rx_ferr", 32'(rx_ferr_o), 0);
        rst_n = 1'b1; tx_en = 1'b1; rx_en = 1'b1;
        repeat (4) @(negedge clk);

        send_tx(8'hA5, 1'b0, 1'b0, 1'b0);

        loop_en = 1'b1;
        cnt0 = rx_cnt;
        send_tx(8'h3C, 1'b1, 1'b0, 1'b0);
        repeat (10) @(negedge clk);
        rx_expect(cnt0, 8'h3C, 1'b0, 1'b0);
        loop_en = 1'b0;

        for (int unsigned i = 0; i < 7; i++) begin
            cnt0 = rx_cnt;
            drive_rx(vecs[i].data, vecs[i].pe, vecs[i].po, vecs[i].flip, vecs[i].stopv, 20);
            rx_expect(cnt0, vecs[i].exp_data, vecs[i].exp_perr, vecs[i].exp_ferr);
        end

        // Short low pulse must be rejected as a false start.
        cnt0 = rx_cnt;
        rx_drive = 1'b0;
        repeat (15) @(negedge clk);
        rx_drive = 1'b1;
        repeat (200) @(negedge clk);
        check("glitch_no_valid", 32'(rx_cnt - cnt0), 0);
        cnt0 = rx_cnt;
        drive_rx(8'h55, 1'b0, 1'b0, 1'b0, 1'b1, 20);
        rx_expect(cnt0, 8'h55, 1'b0, 1'b0);

        // Broken stop bit followed by a held-low line.
        cnt0 = rx_cnt;
        drive_rx(8'h5A, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        rx_drive = 1'b0;
        repeat (200) @(negedge clk);
        rx_expect(cnt0, 8'h5A, 1'b0, 1'b1);
        rx_drive = 1'b1;
        repeat (160) @(negedge clk);
        cnt0 = rx_cnt;
        drive_rx(8'h81, 1'b0, 1'b0, 1'b0, 1'b1, 20);
        rx_expect(cnt0, 8'h81, 1'b0, 1'b0);

        // Receiver disabled part-way through a frame.
        cnt0 = rx_cnt;
        build_frame(8, 9'h0F0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        foreach (fbits[i]) begin
            if (i == 5) rx_en = 1'b0;
            rx_drive = fbits[i];
            repeat (BP) @(negedge clk);
        end
        rx_drive = 1'b1;
        repeat (100) @(negedge clk);
        rx_en = 1'b1;
        repeat (300) @(negedge clk);
        check("rx_disable_no_valid", 32'(rx_cnt - cnt0), 0);

        for (int unsigned i = 0; i < 8; i++) begin
            d = 8'($urandom_range(255));
            pe = 1'($urandom_range(1)); po = 1'($urandom_range(1));
            flip = pe & 1'($urandom_range(1));
            stopv = ($urandom_range(3) != 0);
            cnt0 = rx_cnt;
            drive_rx(d, pe, po, flip, stopv, 20);
            rx_expect(cnt0, d, pe & flip, ~stopv);
        end

        loop_en = 1'b1;
        for (int unsigned i = 0; i < 6; i++) begin
            d = 8'($urandom_range(255));
            pe = 1'($urandom_range(1)); po = 1'($urandom_range(1)); ts = 1'($urandom_range(1));
            cnt0 = rx_cnt;
            send_tx(d, pe, po, ts);
            repeat (10) @(negedge clk);
            rx_expect(cnt0, d, 1'b0, 1'b0);
        end
        loop_en = 1'b0;

        // Reset asserted while data bit 3 of 0xA5 (a zero) is on the line.
        start_tx(8'hA5, 1'b0, 1'b0, 1'b0, got);
        d0 = done_cnt;
        repeat (355) @(negedge clk);
        check("tx_bit3_before_rst", 32'(tx_o), 0);
        rst_n = 1'b0;
        @(negedge clk);
        check("rst_mid_tx_o", 32'(tx_o), 1);
        check("rst_mid_rx_data", 32'(rx_data_o), 0);
        check("rst_mid_rx_valid", 32'(rx_valid_o), 0);
        rst_n = 1'b1;
        repeat (800) @(negedge clk);
        check("rst_mid_no_done", 32'(done_cnt - d0), 0);
        check("rst_mid_ready", 32'(tx_ready_o), 1);

        // 7-bit data, even parity, two stop bits, looped back into its own receiver.
        en7 = 1'b1;
        tx7_data = 7'h7F;
        cnt0 = rx7_cnt;
        got = 0;
        for (int c = 0; c < 100 && !got; c++) begin
            @(negedge clk);
            if (tx7_ready) got = 1;
        end
        check("tx7_ready_wait", 32'(got), 1);
        tx7_valid = 1'b1;
        @(negedge clk);
        tx7_valid = 1'b0;
        t = 0; busy = 0; done = 0;
        for (int c = 0; c < 2000 && !done; c++) begin
            if (c != 0) @(negedge clk);
            t++;
            if (tx7_ready) busy = 1;
            if (tx7_done)  done = 1;
        end
        check_range("tx7_frame_len", t, 11 * BP - P + 1, 11 * BP);
        check("tx7_ready_busy", 32'(busy), 0);
        @(negedge clk);
        check("tx7_ready_after", 32'(tx7_ready), 1);
        repeat (10) @(negedge clk);
        check("rx7_count", 32'(rx7_cnt - cnt0), 1);
        check("rx7_data", 32'(rx7_data), 32'h7F);
        check("rx7_parity_err", 32'(rx7_perr), 0);
        check("rx7_frame_err", 32'(rx7_ferr), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
